// File: rtl/rram_if.sv
`default_nettype none
// ============================================================================
//  Module      : rram_if
//  Description : Command/status bundle between the writeread master and the
//                bit-serial RRAM array. The serial data line is a tristate
//                net and travels as a plain inout port beside this interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rram_if #(
  parameter int AW = 5
);
  logic          rram_ce;
  logic          rram_re;
  logic          rram_we;
  logic          rram_form;
  logic [AW-1:0] rram_add;
  logic          rram_busy;
  logic          rram_err;

  modport master (
    output rram_ce, rram_re, rram_we, rram_form, rram_add,
    input  rram_busy, rram_err
  );

  modport slave (
    input  rram_ce, rram_re, rram_we, rram_form, rram_add,
    output rram_busy, rram_err
  );
endinterface
`default_nettype wire

// File: rtl/rram_serial_array.sv
`default_nettype none
// ============================================================================
//  Module      : rram_serial_array
//  Description : Bit-serial RRAM array. Accepts edge-detected read, write and
//                forming commands, streams words LSB first over a shared
//                one-bit bus, and only commits writes to formed words.
//  Revision    : 1.0 - initial release
// ============================================================================
module rram_serial_array #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int FORM_CYC = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  rram_if.slave   bus,
  inout  wire     rram_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = (FORM_CYC > 1) ? $clog2(FORM_CYC) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [FW-1:0] LAST_FORM = FW'(FORM_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FORM  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]     form_cnt_q, form_cnt_d;
  logic [AW-1:0]     add_q, add_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              oe_q, oe_d;
  logic              re_prev_q, re_prev_d;
  logic              we_prev_q, we_prev_d;
  logic              form_prev_q, form_prev_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  formed_q, formed_d;

  logic [1:0]        n_high;
  logic [1:0]        n_rise;

  // Count command lines that are high, and those that just rose since the last edge.
  assign n_high = {1'b0, bus.rram_re} + {1'b0, bus.rram_we} + {1'b0, bus.rram_form};
  assign n_rise = {1'b0, bus.rram_re   & ~re_prev_q}
                + {1'b0, bus.rram_we   & ~we_prev_q}
                + {1'b0, bus.rram_form & ~form_prev_q};

  // Bus is driven only while streaming a read; the bit follows the live counter.
  assign rram_data     = oe_q ? mem_q[add_q][bit_cnt_q] : 1'bz;
  assign bus.rram_busy = busy_q;
  assign bus.rram_err  = err_q;

  // Next-state logic for the transaction FSM, memory and forming flags.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    form_cnt_d  = form_cnt_q;
    add_d       = add_q;
    shift_d     = shift_q;
    busy_d      = busy_q;
    err_d       = err_q;
    oe_d        = oe_q;
    mem_d       = mem_q;
    formed_d    = formed_q;
    // Previous-edge levels are tracked in every state so a held line never re-triggers.
    re_prev_d   = bus.rram_re;
    we_prev_d   = bus.rram_we;
    form_prev_d = bus.rram_form;

    if (state_q != IDLE && bus.rram_ce) begin
      // Abort: drop everything in flight, leave memory and flags untouched.
      state_d    = IDLE;
      bit_cnt_d  = '0;
      form_cnt_d = '0;
      busy_d     = 1'b0;
      oe_d       = 1'b0;
      err_d      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.rram_ce) begin
            if (n_high == 2'd1 && n_rise == 2'd1) begin
              add_d      = bus.rram_add;
              bit_cnt_d  = '0;
              form_cnt_d = '0;
              shift_d    = '0;
              err_d      = 1'b0;
              busy_d     = 1'b1;
              if (bus.rram_re) begin
                state_d = READ;
                oe_d    = 1'b1;
              end else if (bus.rram_we) begin
                state_d = WRITE;
              end else begin
                state_d = FORM;
              end
            end else if (n_rise > 2'd1) begin
              err_d = 1'b1;
            end
          end
        end
        READ: begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            oe_d      = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        WRITE: begin
          shift_d[bit_cnt_q] = rram_data;
          if (bit_cnt_q == LAST_BIT) begin
            // Unformed cells ignore programming pulses; flag it instead.
            if (formed_q[add_q]) begin
              mem_d[add_q] = shift_d;
            end else begin
              err_d = 1'b1;
            end
            state_d   = IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        FORM: begin
          if (form_cnt_q == LAST_FORM) begin
            formed_d[add_q] = 1'b1;
            state_d         = IDLE;
            form_cnt_d      = '0;
            busy_d          = 1'b0;
          end else begin
            form_cnt_d = form_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State registers; reset wipes the array and forming flags as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      form_cnt_q  <= '0;
      add_q       <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      oe_q        <= 1'b0;
      re_prev_q   <= 1'b0;
      we_prev_q   <= 1'b0;
      form_prev_q <= 1'b0;
      formed_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      form_cnt_q  <= form_cnt_d;
      add_q       <= add_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      oe_q        <= oe_d;
      re_prev_q   <= re_prev_d;
      we_prev_q   <= we_prev_d;
      form_prev_q <= form_prev_d;
      formed_q    <= formed_d;
      mem_q       <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rram_serial_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rram_serial_array
//  Description : Self-checking bench for rram_serial_array against an
//                array-level reference model (words plus forming flags).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rram_serial_array;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 32;
  localparam int AW       = 5;
  localparam int FORM_CYC = 4;

  logic clk;
  logic rst_n;
  logic tb_oe;
  logic tb_bit;
  wire  rram_data;

  int total;
  int bad;

  // Reference model of the array contents.
  logic [WIDTH-1:0] mem_m [DEPTH];
  logic             formed_m [DEPTH];

  rram_if #(.AW(AW)) bus ();

  rram_serial_array #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .FORM_CYC(FORM_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .rram_data(rram_data)
  );

  // A released bus floats high so an unexpected driver of 0 is visible.
  pullup (rram_data);
  assign rram_data = tb_oe ? tb_bit : 1'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]    = '0;
      formed_m[i] = 1'b0;
    end
  endtask

  // ---------------- bus transaction drivers (observe, do not judge) --------
  task automatic do_form(input logic [AW-1:0] a, output int bcnt,
                         output logic busy_o, output logic err_o);
    @(negedge clk);
    bus.rram_ce = 1'b0; bus.rram_form = 1'b1; bus.rram_add = a;
    @(posedge clk); #1;
    bus.rram_form = 1'b0;
    bcnt = 0;
    for (int i = 0; i < FORM_CYC; i++) begin
      @(negedge clk);
      if (bus.rram_busy) bcnt++;
      @(posedge clk);
    end
    @(negedge clk);
    busy_o = bus.rram_busy; err_o = bus.rram_err;
    bus.rram_ce = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                          input int abort_after, output int bcnt,
                          output logic busy_o, output logic err_o, output logic data_o);
    @(negedge clk);
    bus.rram_ce = 1'b0; bus.rram_we = 1'b1; bus.rram_add = a;
    @(posedge clk); #1;
    bus.rram_we = 1'b0;
    tb_oe = 1'b1;
    bcnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == abort_after) begin
        bus.rram_ce = 1'b1;
        tb_oe = 1'b0;
      end
      tb_bit = d[i];
      @(negedge clk);
      if (bus.rram_busy) bcnt++;
      @(posedge clk); #1;
      if (i == abort_after) break;
    end
    tb_oe = 1'b0;
    @(negedge clk);
    busy_o = bus.rram_busy; err_o = bus.rram_err; data_o = rram_data;
    bus.rram_ce = 1'b1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [WIDTH-1:0] word,
                         output int bcnt, output logic busy_o, output logic err_o,
                         output logic data_o);
    @(negedge clk);
    bus.rram_ce = 1'b0; bus.rram_re = 1'b1; bus.rram_add = a;
    @(posedge clk); #1;
    bus.rram_re = 1'b0;
    word = '0;
    bcnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      word[i] = rram_data;
      if (bus.rram_busy) bcnt++;
    end
    @(negedge clk);
    busy_o = bus.rram_busy; err_o = bus.rram_err; data_o = rram_data;
    bus.rram_ce = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [WIDTH-1:0] w;
    int bc;
    logic b, e, dz;
    #12;
    total++;
    if (bus.rram_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.rram_busy); end
    total++;
    if (bus.rram_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.rram_err); end
    total++;
    if (rram_data !== 1'b1) begin bad++; $display("FAIL reset_bus_released got=%b want=pulled 1", rram_data); end
    @(negedge clk);
    rst_n = 1'b1;
    do_read(5'd12, w, bc, b, e, dz);
    total++;
    if (w !== mem_m[12]) begin bad++; $display("FAIL reset_mem_zero got=%h want=%h", w, mem_m[12]); end
  endtask

  task automatic test_form_write_read();
    logic [WIDTH-1:0] w;
    int bc;
    logic b, e, dz;
    do_form(5'd3, bc, b, e);
    formed_m[3] = 1'b1;
    total++;
    if (bc !== FORM_CYC || b !== 1'b0 || e !== 1'b0) begin
      bad++; $display("FAIL form_busy busy_cycles=%0d busy_after=%b err=%b want %0d,0,0", bc, b, e, FORM_CYC);
    end
    do_write(5'd3, 32'hB6DB_6DB6, -1, bc, b, e, dz);
    if (formed_m[3]) mem_m[3] = 32'hB6DB_6DB6;
    total++;
    if (bc !== WIDTH || b !== 1'b0 || e !== 1'b0) begin
      bad++; $display("FAIL write_busy busy_cycles=%0d busy_after=%b err=%b want %0d,0,0", bc, b, e, WIDTH);
    end
    do_read(5'd3, w, bc, b, e, dz);
    total++;
    if (w !== 32'hB6DB_6DB6) begin bad++; $display("FAIL read_formed got=%h want=%h", w, 32'hB6DB_6DB6); end
    total++;
    if (bc !== WIDTH || b !== 1'b0 || e !== 1'b0 || dz !== 1'b1) begin
      bad++; $display("FAIL read_busy busy_cycles=%0d busy_after=%b err=%b bus=%b want %0d,0,0,1", bc, b, e, dz, WIDTH);
    end
  endtask

  task automatic test_unformed_write();
    logic [WIDTH-1:0] w;
    int bc;
    logic b, e, dz;
    do_write(5'd7, 32'hFFFF_FFFF, -1, bc, b, e, dz);
    total++;
    if (e !== !formed_m[7]) begin bad++; $display("FAIL unformed_err got=%b want=%b", e, !formed_m[7]); end
    do_read(5'd7, w, bc, b, e, dz);
    total++;
    if (w !== mem_m[7]) begin bad++; $display("FAIL unformed_read got=%h want=%h", w, mem_m[7]); end
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL err_clear_on_accept got=%b want=0", e); end
  endtask

  task automatic test_abort_write();
    logic [WIDTH-1:0] w;
    int bc;
    logic b, e, dz;
    do_form(5'd0, bc, b, e);
    formed_m[0] = 1'b1;
    do_write(5'd0, 32'h1234_5678, 10, bc, b, e, dz);
    total++;
    if (bc !== 11 || b !== 1'b0 || e !== 1'b1) begin
      bad++; $display("FAIL abort_state busy_cycles=%0d busy_after=%b err=%b want 11,0,1", bc, b, e);
    end
    total++;
    if (dz !== 1'b1) begin bad++; $display("FAIL abort_bus_released got=%b want=pulled 1", dz); end
    do_read(5'd0, w, bc, b, e, dz);
    total++;
    if (w !== mem_m[0]) begin bad++; $display("FAIL abort_mem_untouched got=%h want=%h", w, mem_m[0]); end
  endtask

  task automatic test_command_protocol();
    logic [WIDTH-1:0] w;
    int bc, rises;
    logic b, e, prev_busy;
    // Hold re high through two read lengths: only one transaction may occur.
    @(negedge clk);
    bus.rram_ce = 1'b0; bus.rram_re = 1'b1; bus.rram_add = 5'd3;
    w = '0; bc = 0; rises = 0; prev_busy = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2 * WIDTH + 6; i++) begin
      @(negedge clk);
      if (i < WIDTH) w[i] = rram_data;
      if (bus.rram_busy) bc++;
      if (bus.rram_busy && !prev_busy) rises++;
      prev_busy = bus.rram_busy;
    end
    total++;
    if (bc !== WIDTH || rises !== 1) begin
      bad++; $display("FAIL held_re_single busy_cycles=%0d transactions=%0d want %0d,1", bc, rises, WIDTH);
    end
    total++;
    if (w !== mem_m[3]) begin bad++; $display("FAIL held_re_data got=%h want=%h", w, mem_m[3]); end
    bus.rram_re = 1'b0; bus.rram_ce = 1'b1;
    // re and we rise together.
    @(negedge clk);
    bus.rram_ce = 1'b0; bus.rram_re = 1'b1; bus.rram_we = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bus.rram_busy !== 1'b0 || bus.rram_err !== 1'b1) begin
      bad++; $display("FAIL dual_cmd busy=%b err=%b want 0,1", bus.rram_busy, bus.rram_err);
    end
    bus.rram_re = 1'b0; bus.rram_we = 1'b0; bus.rram_ce = 1'b1;
    do_form(5'd9, bc, b, e);
    formed_m[9] = 1'b1;
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL err_clear_after_dual got=%b want=0", e); end
  endtask

  task automatic test_addr_boundary();
    logic [WIDTH-1:0] w0, w31;
    int bc;
    logic b, e, dz;
    do_form(5'd0, bc, b, e);  formed_m[0]  = 1'b1;
    do_form(5'd31, bc, b, e); formed_m[31] = 1'b1;
    do_write(5'd0, 32'h0000_0001, -1, bc, b, e, dz);  mem_m[0]  = 32'h0000_0001;
    do_write(5'd31, 32'h8000_0000, -1, bc, b, e, dz); mem_m[31] = 32'h8000_0000;
    do_read(5'd0, w0, bc, b, e, dz);
    do_read(5'd31, w31, bc, b, e, dz);
    total++;
    if (w0 !== 32'h0000_0001) begin bad++; $display("FAIL addr0 got=%h want=%h", w0, 32'h0000_0001); end
    total++;
    if (w31 !== 32'h8000_0000) begin bad++; $display("FAIL addr31 got=%h want=%h", w31, 32'h8000_0000); end
  endtask

  task automatic test_reset_mid_form();
    logic [WIDTH-1:0] w;
    int bc;
    logic b, e, dz;
    @(negedge clk);
    bus.rram_ce = 1'b0; bus.rram_form = 1'b1; bus.rram_add = 5'd5;
    @(posedge clk); #1;
    bus.rram_form = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    total++;
    if (bus.rram_busy !== 1'b1) begin bad++; $display("FAIL form_in_progress busy=%b want=1", bus.rram_busy); end
    rst_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (bus.rram_busy !== 1'b0 || bus.rram_err !== 1'b0 || rram_data !== 1'b1) begin
      bad++; $display("FAIL async_reset busy=%b err=%b bus=%b want 0,0,1", bus.rram_busy, bus.rram_err, rram_data);
    end
    @(negedge clk);
    bus.rram_ce = 1'b1;
    rst_n = 1'b1;
    do_write(5'd5, 32'hA5A5_A5A5, -1, bc, b, e, dz);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL write_after_reset_err got=%b want=1", e); end
    do_read(5'd3, w, bc, b, e, dz);
    total++;
    if (w !== mem_m[3]) begin bad++; $display("FAIL mem_cleared_by_reset got=%h want=%h", w, mem_m[3]); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w, d;
    logic [AW-1:0] a;
    int bc, op;
    logic b, e, dz;
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 2));
      a  = AW'($urandom_range(0, DEPTH - 1));
      d  = $urandom;
      if (op == 0) begin
        do_form(a, bc, b, e);
        formed_m[a] = 1'b1;
        total++;
        if (e !== 1'b0 || bc !== FORM_CYC) begin
          bad++; $display("FAIL rand_form addr=%0d err=%b busy_cycles=%0d want 0,%0d", a, e, bc, FORM_CYC);
        end
      end else if (op == 1) begin
        do_write(a, d, -1, bc, b, e, dz);
        total++;
        if (e !== !formed_m[a]) begin
          bad++; $display("FAIL rand_write_err addr=%0d got=%b want=%b", a, e, !formed_m[a]);
        end
        if (formed_m[a]) mem_m[a] = d;
      end else begin
        do_read(a, w, bc, b, e, dz);
        total++;
        if (w !== mem_m[a] || e !== 1'b0) begin
          bad++; $display("FAIL rand_read addr=%0d got=%h err=%b want=%h err=0", a, w, e, mem_m[a]);
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    tb_oe = 1'b0; tb_bit = 1'b0;
    bus.rram_ce = 1'b1; bus.rram_re = 1'b0; bus.rram_we = 1'b0;
    bus.rram_form = 1'b0; bus.rram_add = '0;
    model_clear();
    test_reset();
    test_form_write_read();
    test_unformed_write();
    test_abort_write();
    test_command_protocol();
    test_addr_boundary();
    test_reset_mid_form();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
